// File: rtl/saratoga.sv
// Shared types and constants for the multi-cycle RV32M divider.
package saratoga;

  typedef enum logic [1:0] {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  localparam int unsigned DIV_ITERATIONS = 32;

  function automatic logic is_signed_op(div_op_t op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic is_rem_op(div_op_t op);
    return (op == DIV_REM) || (op == DIV_REMU);
  endfunction

  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] abs32(logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] dvs_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {rem_i[31:0], quo_i[31]};
    diff    = {rem_i, quo_i[31]} - {2'b00, dvs_i};
    rem_o   = diff[33] ? shifted : diff[32:0];
    quo_o   = {quo_i[30:0], ~diff[33]};
  end

endmodule

// File: rtl/mdu_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit; define DIV_EARLY_OUT_EN to finish
// trivial cases (special values, divisor 1, small unsigned dividend) straight from IDLE.
module mdu_divider
  import saratoga::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  div_op_t     div_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  div_state_t  state_q, state_d;
  div_op_t     op_q, op_d;
  logic        quo_neg_q, quo_neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  count_q, count_d;
  logic        special_q, special_d;
  logic [31:0] special_val_q, special_val_d;
  logic [31:0] result_q, result_d;

  logic [32:0] step_rem;
  logic [31:0] step_quo;
  logic        signed_op, rem_op, div_zero, div_ovf;
  logic [31:0] special_val;

  div_step u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    signed_op   = is_signed_op(div_op);
    rem_op      = is_rem_op(div_op);
    div_zero    = (src2 == 32'd0);
    div_ovf     = signed_op && (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF);
    special_val = div_zero ? (rem_op ? src1 : 32'hFFFF_FFFF)
                           : (rem_op ? 32'd0 : 32'h8000_0000);

    state_d       = state_q;
    op_d          = op_q;
    quo_neg_d     = quo_neg_q;
    rem_neg_d     = rem_neg_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    count_d       = count_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    result_d      = result_q;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d          = div_op;
          quo_neg_d     = signed_op && (src1[31] ^ src2[31]);
          rem_neg_d     = signed_op && src1[31];
          quo_d         = signed_op ? abs32(src1) : src1;
          dvs_d         = signed_op ? abs32(src2) : src2;
          rem_d         = 33'd0;
          count_d       = 5'd0;
          special_d     = div_zero || div_ovf;
          special_val_d = special_val;
          state_d       = CALC;
`ifdef DIV_EARLY_OUT_EN
          if (div_zero || div_ovf) begin
            result_d = special_val;
            state_d  = DONE;
          end else if (src2 == 32'd1) begin
            result_d = rem_op ? 32'd0 : src1;
            state_d  = DONE;
          end else if (!signed_op && (src1 < src2)) begin
            result_d = rem_op ? src1 : 32'd0;
            state_d  = DONE;
          end
`endif
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + 5'd1;
          if (count_q == 5'(DIV_ITERATIONS - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (special_q) begin
            result_d = special_val_q;
          end else if (is_rem_op(op_q)) begin
            result_d = rem_neg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
          end else begin
            result_d = quo_neg_q ? (~quo_q + 32'd1) : quo_q;
          end
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= DIV_DIV;
      quo_neg_q     <= 1'b0;
      rem_neg_q     <= 1'b0;
      rem_q         <= 33'd0;
      quo_q         <= 32'd0;
      dvs_q         <= 32'd0;
      count_q       <= 5'd0;
      special_q     <= 1'b0;
      special_val_q <= 32'd0;
      result_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      quo_neg_q     <= quo_neg_d;
      rem_neg_q     <= rem_neg_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      count_q       <= count_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      result_q      <= result_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE) && !flush;
  assign result = result_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Directed-vector bench for mdu_divider; latency expectations follow DIV_EARLY_OUT_EN.
module tb_mdu_divider;
  import saratoga::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  div_op_t     div_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int vectors = 0;
  int errors  = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int SpecLat = 1;
`else
  localparam int SpecLat = 34;
`endif

  always #5 clk = ~clk;

  mdu_divider dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .div_op (div_op),
    .src1   (src1),
    .src2   (src2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Issue in cycle N, then watch cycles N+1.. for done (bounded).
  task automatic run_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_cycles);
    @(negedge clk);
    start = 1'b1; div_op = op; src1 = a; src2 = b;
    lat = 0; busy_cycles = 0; res = 32'd0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; div_op = DIV_DIV; src1 = '0; src2 = '0;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++;
    if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [31:0] res; int lat; int bc;
    run_op(DIV_DIVU, 32'd100, 32'd7, res, lat, bc);
    vectors++; if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h want %h", res, 32'd14); end
    vectors++; if (lat !== 34) begin errors++; $display("FAIL divu_latency: got %0d want 34", lat); end
    vectors++; if (bc !== 34) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 34", bc); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL divu_after_done: got busy=%b done=%b want 0 0", busy, done);
    end
    run_op(DIV_REMU, 32'd100, 32'd7, res, lat, bc);
    vectors++; if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h want %h", res, 32'd2); end
    vectors++; if (lat !== 34) begin errors++; $display("FAIL remu_latency: got %0d want 34", lat); end
    run_op(DIV_DIVU, 32'd1000, 32'd1000, res, lat, bc);
    vectors++; if (res !== 32'd1) begin errors++; $display("FAIL divu_equal: got %h want 1", res); end
  endtask

  task automatic test_signed();
    logic [31:0] res; int lat; int bc;
    run_op(DIV_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, bc);
    vectors++;
    if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2: got %h want fffffffd", res); end
    vectors++; if (lat !== 34) begin errors++; $display("FAIL div_latency: got %0d want 34", lat); end
    run_op(DIV_REM, 32'hFFFF_FFF9, 32'd2, res, lat, bc);
    vectors++;
    if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: got %h want ffffffff", res); end
    run_op(DIV_REM, 32'd7, 32'hFFFF_FFFE, res, lat, bc);
    vectors++; if (res !== 32'd1) begin errors++; $display("FAIL rem_7_m2: got %h want 1", res); end
    run_op(DIV_DIV, 32'h8000_0000, 32'd2, res, lat, bc);
    vectors++;
    if (res !== 32'hC000_0000) begin errors++; $display("FAIL div_min_2: got %h want c0000000", res); end
    run_op(DIV_DIV, 32'd7, 32'hFFFF_FFFE, res, lat, bc);
    vectors++;
    if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2: got %h want fffffffd", res); end
  endtask

  task automatic test_special();
    logic [31:0] res; int lat; int bc;
    run_op(DIV_DIV, 32'h1234_5678, 32'd0, res, lat, bc);
    vectors++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero: got %h want ffffffff", res); end
    vectors++; if (lat !== SpecLat) begin errors++; $display("FAIL div_by_zero_lat: got %0d want %0d", lat, SpecLat); end
    run_op(DIV_REMU, 32'h1234_5678, 32'd0, res, lat, bc);
    vectors++; if (res !== 32'h1234_5678) begin errors++; $display("FAIL remu_by_zero: got %h want 12345678", res); end
    vectors++; if (lat !== SpecLat) begin errors++; $display("FAIL remu_by_zero_lat: got %0d want %0d", lat, SpecLat); end
    run_op(DIV_REM, 32'hFFFF_FFF9, 32'd0, res, lat, bc);
    vectors++; if (res !== 32'hFFFF_FFF9) begin errors++; $display("FAIL rem_by_zero: got %h want fffffff9", res); end
    run_op(DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bc);
    vectors++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h want 80000000", res); end
    vectors++; if (lat !== SpecLat) begin errors++; $display("FAIL div_overflow_lat: got %0d want %0d", lat, SpecLat); end
    run_op(DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, bc);
    vectors++; if (res !== 32'd0) begin errors++; $display("FAIL rem_overflow: got %h want 0", res); end
    run_op(DIV_DIVU, 32'd5, 32'd1, res, lat, bc);
    vectors++; if (res !== 32'd5) begin errors++; $display("FAIL divu_by_one: got %h want 5", res); end
    run_op(DIV_REMU, 32'd3, 32'd10, res, lat, bc);
    vectors++; if (res !== 32'd3) begin errors++; $display("FAIL remu_small: got %h want 3", res); end
    run_op(DIV_DIVU, 32'd3, 32'd10, res, lat, bc);
    vectors++; if (res !== 32'd0) begin errors++; $display("FAIL divu_small: got %h want 0", res); end
  endtask

  task automatic test_back_to_back();
    int done_k = 0; int dones = 0; logic [31:0] res = 32'd0;
    @(negedge clk);
    start = 1'b1; div_op = DIV_DIVU; src1 = 32'd100; src2 = 32'd7;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) begin div_op = DIV_DIV; src1 = 32'd50; src2 = 32'd5; end
      if (done) begin dones++; if (done_k == 0) begin done_k = k; res = result; end end
    end
    vectors++; if (done_k !== 34) begin errors++; $display("FAIL ignore_start_lat: got %0d want 34", done_k); end
    vectors++; if (res !== 32'd14) begin errors++; $display("FAIL ignore_start_result: got %h want %h", res, 32'd14); end
    vectors++; if (dones !== 1) begin errors++; $display("FAIL ignore_start_dones: got %0d want 1", dones); end
  endtask

  task automatic test_flush();
    int done_k = 0; int dones = 0; logic [31:0] res = 32'd0; logic busy11 = 1'b1;
    @(negedge clk);
    start = 1'b1; div_op = DIV_DIVU; src1 = 32'd100; src2 = 32'd7;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      flush = (k == 10);
      start = (k == 12);
      if (k == 12) begin div_op = DIV_DIVU; src1 = 32'd1000; src2 = 32'd3; end
      if (k == 11) busy11 = busy;
      if (done) begin dones++; if (done_k == 0) begin done_k = k; res = result; end end
    end
    vectors++; if (busy11 !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b want 0", busy11); end
    vectors++; if (done_k !== 46) begin errors++; $display("FAIL flush_restart_lat: got %0d want 46", done_k); end
    vectors++; if (dones !== 1) begin errors++; $display("FAIL flush_dones: got %0d want 1", dones); end
    vectors++; if (res !== 32'd333) begin errors++; $display("FAIL flush_restart_result: got %h want %h", res, 32'd333); end
    @(negedge clk);
    start = 1'b1; flush = 1'b1; div_op = DIV_DIVU; src1 = 32'd9; src2 = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start: got busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset();
    logic [31:0] res; int lat; int bc;
    @(negedge clk);
    start = 1'b1; div_op = DIV_DIVU; src1 = 32'd100; src2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL async_rst_done: got %b want 0", done); end
    vectors++; if (result !== 32'd0) begin errors++; $display("FAIL async_rst_result: got %h want 0", result); end
    @(negedge clk);
    rst = 1'b0;
    run_op(DIV_DIVU, 32'hFFFF_FFFF, 32'h10, res, lat, bc);
    vectors++; if (res !== 32'h0FFF_FFFF) begin errors++; $display("FAIL post_rst_divu: got %h want 0fffffff", res); end
    vectors++; if (lat !== 34) begin errors++; $display("FAIL post_rst_lat: got %0d want 34", lat); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mdu_divider.md
Name: mdu_divider

Overview:
- Iterative radix-2 restoring divider implementing RV32M DIV, DIVU, REM and REMU.
- Sits in the execute stage beside the single-cycle ALU. It handles the operations the ALU cannot complete in one cycle.
- Execute/hazard control issues an operation with a start pulse, stalls on busy, and captures the result on the done pulse.

Parameters:
- none; the datapath is fixed at rv32 word width (32 bits).

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  issue request; sampled only in IDLE
- div_op  input  div_op_t  DIV_DIV, DIV_DIVU, DIV_REM or DIV_REMU
- src1  input  32  dividend (rv32::signed_word)
- src2  input  32  divisor (rv32::signed_word)
- flush  input  1  abort the in-flight operation (pipeline kill)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse; result is valid in that cycle
- result  output  32  quotient or remainder (rv32::signed_word)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
  - Reset asserted mid-operation discards the operation immediately; no done is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start=1, latch div_op, operand signs, |src1| and |src2|, then go to CALC with count=0.
  - DIVU/REMU use raw unsigned operands; the signed magnitude step is skipped.
- CALC, one iteration per cycle:
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor magnitude from the 33-bit remainder. If non-negative, keep the difference and set quo[0]=1.
  - After 32 iterations (count==31), go to FIX.
- FIX, sign correction:
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
  - Register result; go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. result holds its value until the next FIX (or special-case completion).
- Latency: start in cycle N gives CALC in N+1..N+32, FIX in N+33 and done in N+34. Throughput is one operation per 35 cycles.
- Special cases (RISC-V mandated, exact values):
  - divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give src1.
  - DIV of 0x80000000 by 0xFFFFFFFF gives 0x80000000; REM gives 0.
  - Flags for both cases are latched in IDLE. FIX overrides sign correction with these values.
- start while busy=1 is ignored; the operands are not latched.
- flush=1 in CALC, FIX or DONE: next state is IDLE, done is suppressed in that cycle and later cycles, and result is unchanged.
- flush=1 together with start=1 in IDLE: flush wins and no operation starts.
- Arithmetic: remainder register is 33 bits so the trial subtraction cannot overflow. Magnitude of 0x80000000 is 0x80000000 as unsigned.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - IDLE detects the special cases, plus divisor==1 (all ops) and unsigned dividend < divisor (DIVU/REMU).
  - These go straight to DONE with the final result registered. done is asserted in N+1.
  - divisor==1 results: DIV/DIVU give src1; REM/REMU give 0.
  - Unsigned dividend < divisor results: DIVU gives 0; REMU gives src1.
- Undefined: every operation takes the full 35-cycle path. Result values are identical in both builds.

Decomposition:
- Package saratoga:
  - div_op_t enum (DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU).
  - div_state_t enum (IDLE, CALC, FIX, DONE).
  - localparam DIV_ITERATIONS=32.
- Natural sub-module: div_step, a combinational single-iteration shift/trial-subtract on a 33-bit remainder and 32-bit quotient, instanced once in CALC.

Test Plan:
- DIVU 100/7 with start at cycle N -> busy in N+1..N+34, done only in N+34, result=14; repeat as REMU -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- Divide-by-zero with src1=0x12345678 -> DIV=0xFFFFFFFF, REMU=0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. With DIV_EARLY_OUT_EN, done arrives in N+1.
- start pulsed again in N+5 with different operands -> ignored; N+34 result still matches the first operation.
- flush in N+10 -> IDLE in N+11, no done pulse ever; a new start in N+12 completes normally in N+46.
- rst asserted asynchronously mid-CALC -> busy, done and result are 0 immediately, without waiting for a clock edge; a post-reset DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF.
